// File: rtl/hififo_wr_arb.sv
// Round-robin write-request arbiter: merges four TPC FIFO beat streams into one
// registered stream, holding each grant for a whole burst so TLP payloads never interleave.

module hififo_wr_arb_lane #(
  parameter bit EN = 1'b1
) (
  input  logic run,
  input  logic sel,
  input  logic burst,
  input  logic out_free,
  input  logic valid,
  output logic req,
  output logic ready
);
  assign req   = EN & valid;
  // run is reset_n: ready must drop combinationally while reset is held
  assign ready = EN & run & burst & sel & out_free;
endmodule

module hififo_wr_arb #(
  parameter logic [3:0] ENABLE    = 4'b1111,
  parameter int         MAX_BEATS = 16
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [3:0]  wri_valid,
  output logic [3:0]  wri_ready,
  input  logic [3:0]  wri_last,
  input  logic [63:0] wri_addr_0,
  input  logic [63:0] wri_addr_1,
  input  logic [63:0] wri_addr_2,
  input  logic [63:0] wri_addr_3,
  input  logic [63:0] wri_data_0,
  input  logic [63:0] wri_data_1,
  input  logic [63:0] wri_data_2,
  input  logic [63:0] wri_data_3,
  output logic        wro_valid,
  input  logic        wro_ready,
  output logic [63:0] wro_addr,
  output logic [63:0] wro_data,
  output logic        wro_last,
  output logic [1:0]  wro_chan,
  output logic        overrun
);
  localparam int NUM_LANES = 4;
  localparam int CW        = $clog2(MAX_BEATS) + 1;

  typedef enum logic {IDLE, BURST} state_t;

  typedef struct packed {
    logic [63:0] addr;
    logic [63:0] data;
    logic        last;
  } beat_t;

  state_t          state_q, state_d;
  logic [1:0]      ptr_q, ptr_d;
  logic [1:0]      gnt_q, gnt_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            ovr_q, ovr_d;
  logic            ov_q, ov_d;
  beat_t           out_q, out_d;
  logic [1:0]      chan_q, chan_d;

  beat_t [NUM_LANES-1:0] lane_beat;
  logic  [NUM_LANES-1:0] req;
  logic  [1:0]           pick;
  logic                  out_free;
  logic                  accept;

  assign lane_beat[0] = '{addr: wri_addr_0, data: wri_data_0, last: wri_last[0]};
  assign lane_beat[1] = '{addr: wri_addr_1, data: wri_data_1, last: wri_last[1]};
  assign lane_beat[2] = '{addr: wri_addr_2, data: wri_data_2, last: wri_last[2]};
  assign lane_beat[3] = '{addr: wri_addr_3, data: wri_data_3, last: wri_last[3]};

  assign out_free = ~ov_q | wro_ready;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    hififo_wr_arb_lane #(.EN(ENABLE[i])) u_lane (
      .run      (reset_n),
      .sel      (gnt_q == 2'(i)),
      .burst    (state_q == BURST),
      .out_free (out_free),
      .valid    (wri_valid[i]),
      .req      (req[i]),
      .ready    (wri_ready[i])
    );
  end

  assign accept = wri_valid[gnt_q] & wri_ready[gnt_q];

  // first requester at or after ptr, wrapping mod 4
  always_comb begin
    logic       found;
    logic [1:0] idx;
    pick  = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      idx = ptr_q + 2'(i);
      if (!found && req[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    cnt_d   = cnt_q;
    ovr_d   = ovr_q;
    ov_d    = ov_q;
    out_d   = out_q;
    chan_d  = chan_q;
    if (ov_q && wro_ready) ov_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (|req) begin
          gnt_d   = pick;
          ptr_d   = pick + 2'd1;
          cnt_d   = '0;
          state_d = BURST;
        end
      end
      BURST: begin
        if (accept) begin
          ov_d   = 1'b1;
          out_d  = lane_beat[gnt_q];
          chan_d = gnt_q;
          cnt_d  = cnt_q + 1'b1;
          if (lane_beat[gnt_q].last) state_d = IDLE;
          else if (cnt_q == CW'(MAX_BEATS - 1)) ovr_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      gnt_q   <= '0;
      cnt_q   <= '0;
      ovr_q   <= 1'b0;
      ov_q    <= 1'b0;
      out_q   <= '0;
      chan_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      cnt_q   <= cnt_d;
      ovr_q   <= ovr_d;
      ov_q    <= ov_d;
      out_q   <= out_d;
      chan_q  <= chan_d;
    end
  end

  assign wro_valid = ov_q;
  assign wro_addr  = out_q.addr;
  assign wro_data  = out_q.data;
  assign wro_last  = out_q.last;
  assign wro_chan  = chan_q;
  assign overrun   = ovr_q;

endmodule
